gpr_file_mp: RTL and testbench

// - Parametrised multi-read-port general-purpose register file for the CPU core; successor to the fixed 2R1W 64x32 GPR.
// - Registered (1-cycle) reads with per-file output hold for pipeline stalls.
// - Hardwired zero register; self-clearing init sweep after reset with a ready flag.
// - Sits between decode (read addresses) and writeback (write port).

---
 rtl/gpr_file_mp.sv | 63 ++++++
 tb/tb_gpr_file_mp.sv | 131 +++++++++++++
 2 files changed

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: NRD-read/1-write register file, registered reads with hold, zero reg and init sweep.
// Macro GPR_BYPASS_EN selects write-first reads on a same-edge address match (default read-first).
module gpr_file_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic                 read_hold,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic                 ready
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [AW:0] NR = (AW+1)'(NREG);
  state_t state, state_nxt;
  logic [AW-1:0] ptr;
  logic [XLEN-1:0] mem [NREG];
  logic we;
  // an address that holds real data: in range and not the hardwired zero reg
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < NR) && !(ZERO_REG != 0 && a == '0);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= (state == INIT) ? ptr + 1'b1 : '0;
    end
  end
  always_comb state_nxt = (state == INIT && {1'b0, ptr} == NR - 1'b1) ? RUN : state;
  always_comb ready = (state == RUN);
  assign we = (state == RUN) && wr_en && live(wr_addr);
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[ptr] <= '0;
      else if (we) mem[wr_addr] <= wr_data;
    end
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] q, r;
    assign a = rd_addr[p*AW +: AW];
`ifdef GPR_BYPASS_EN
    assign q = !live(a) ? '0 : (we && wr_addr == a) ? wr_data : mem[a];
`else
    assign q = live(a) ? mem[a] : '0;
`endif
    always_ff @(posedge clk) begin
      if (rst || state == INIT) r <= '0;
      else if (!read_hold) r <= q;
    end
    assign rd_data[p*XLEN +: XLEN] = r;
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: directed and random stimulus against an array model of the register file.
// Build with or without GPR_BYPASS_EN, matching the RTL build.
module tb_gpr_file_mp;
  localparam int N = 32;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  logic clk = 0, rst, read_hold, wr_en, ready;
  logic [9:0] rd_addr;
  logic [4:0] wr_addr;
  logic [63:0] wr_data;
  logic [127:0] rd_data;
  int checks = 0, errors = 0;

  gpr_file_mp dut (.clk(clk), .rst(rst), .rd_addr(rd_addr), .read_hold(read_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready));

  always #5 clk = ~clk;

  // model: register contents as a plain array, sweep as a countdown of remaining cycles
  logic [63:0] m [N];
  logic [63:0] e [2];
  int left = N;
  bit started = 0;
  logic [4:0] ma;
  always @(posedge clk) begin
    if (rst) begin
      left = N;
      e[0] = 0;
      e[1] = 0;
      started = 1;
    end else if (left > 0) begin
      left--;
      e[0] = 0;
      e[1] = 0;
      if (left == 0) for (int i = 0; i < N; i++) m[i] = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ma = rd_addr[p*5 +: 5];
        if (!read_hold)
          e[p] = (ma == 0) ? 64'd0 : (BYP && wr_en && wr_addr == ma) ? wr_data : m[ma];
      end
      if (wr_en && wr_addr != 0) m[wr_addr] = wr_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_ready", {63'd0, ready}, {63'd0, left == 0});
      chk("model_p0", rd_data[63:0], e[0]);
      chk("model_p1", rd_data[127:64], e[1]);
    end
  end

  task automatic step(input logic r, input logic h, input logic [4:0] a0, input logic [4:0] a1,
                      input logic w, input logic [4:0] wa, input logic [63:0] wd);
    rst = r;
    read_hold = h;
    rd_addr = {a1, a0};
    wr_en = w;
    wr_addr = wa;
    wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; read_hold = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    @(negedge clk);
    for (int i = 1; i <= N; i++) begin
      idle();
      chk("sweep_ready", {63'd0, ready}, {63'd0, i == N});
    end
    for (int i = 0; i < N; i++) begin
      step(0, 0, 5'(i), 5'(N-1-i), 0, 0, 0);
      chk("clear_p0", rd_data[63:0], 64'd0);
      chk("clear_p1", rd_data[127:64], 64'd0);
    end
    step(0, 0, 0, 0, 1, 5, 64'hDEAD_BEEF_0123_4567);
    step(0, 0, 5, 0, 0, 0, 0);
    chk("read_r5", rd_data[63:0], 64'hDEAD_BEEF_0123_4567);
    step(0, 0, 0, 0, 1, 0, '1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("zero_reg", rd_data[63:0], 64'd0);
    step(0, 0, 0, 5, 0, 0, 0);
    chk("hold_capture", rd_data[127:64], 64'hDEAD_BEEF_0123_4567);
    step(0, 1, 0, 9, 1, 5, 64'h1);
    chk("hold_frozen", rd_data[127:64], 64'hDEAD_BEEF_0123_4567);
    step(0, 0, 0, 5, 0, 0, 0);
    chk("hold_release", rd_data[127:64], 64'h1);
    step(0, 0, 0, 0, 1, 7, 64'h55);
    step(0, 0, 7, 0, 1, 7, 64'hAA);
    chk("same_edge", rd_data[63:0], BYP ? 64'hAA : 64'h55);
    step(0, 0, 7, 0, 0, 0, 0);
    chk("after_same_edge", rd_data[63:0], 64'hAA);
    step(0, 0, 0, 0, 1, 3, 64'h77);
    step(0, 0, 3, 0, 0, 0, 0);
    chk("read_r3", rd_data[63:0], 64'h77);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_rd", rd_data[63:0], 64'd0);
    for (int i = 1; i <= N; i++) begin
      step(0, 0, 3, 9, i == 5, 9, 64'h123);
      chk("resweep_ready", {63'd0, ready}, {63'd0, i == N});
    end
    step(0, 0, 3, 9, 0, 0, 0);
    chk("r3_cleared", rd_data[63:0], 64'd0);
    chk("init_write_lost", rd_data[127:64], 64'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0,
           5'($urandom_range(0, N-1)), 5'($urandom_range(0, N-1)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, N-1)),
           {$urandom, $urandom});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
